// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants and types for the sprite ROM arbiter and its clients.
// Combinational only: no latency, no backpressure.
// Requester ids name the overlay stages that share the sprite ROM.
package spritePkg;

    localparam int REQ_LADDER = 0;
    localparam int REQ_RAMP   = 1;
    localparam int REQ_DECOR  = 2;
    localparam int REQ_BARREL = 3;

    localparam int SPRITE_ADDR_W = 10;
    localparam int SPRITE_DATA_W = 12;
    localparam int SPRITE_ID_W   = 3;
    localparam int STAT_W        = 16;

    typedef struct packed {
        logic                     valid;
        logic [SPRITE_ID_W-1:0]   id;
        logic [SPRITE_DATA_W-1:0] data;
    } sprite_rsp_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin priority picker: first set req at or above ptr, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; gnt is all-zero when req is empty.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [IW:0] cand;
    logic        found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // one extra bit so ptr+k never overflows before the wrap compare
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && req[cand[IW-1:0]]) begin
                found               = 1'b1;
                gnt[cand[IW-1:0]]   = 1'b1;
                idx                 = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one sync sprite ROM; SPRITE_ARB_STATS_EN adds grant counters.
// Latency: 1+ROM_LAT cycles from accept to rsp_valid, one access per cycle.
// Backpressure: requesters hold req/addr until gnt; responses cannot be stalled.
module sprite_rom_arbiter
    import spritePkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SPRITE_ADDR_W,
    parameter int DATA_W  = SPRITE_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_data,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         busy
`ifdef SPRITE_ARB_STATS_EN
    ,
    input  logic                         frame_clr,
    output logic [NUM_REQ*STAT_W-1:0]    grant_cnt
`endif
);

    localparam int             IDW     = $clog2(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } stage_t;

    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     pick_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               accept;
    logic [ADDR_W-1:0]  win_addr;
    stage_t             stage_q [ROM_LAT];

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign gnt      = rst_n ? pick_gnt : '0;
    assign accept   = |gnt;
    assign win_addr = req_addr[ADDR_W*int'(pick_idx) +: ADDR_W];

    // rom_addr only moves on an accept so the ROM bus stays quiet when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            rom_addr <= '0;
        end else if (accept) begin
            rom_addr <= win_addr;
            rr_ptr   <= (pick_idx == LAST_ID) ? '0 : pick_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < ROM_LAT; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= {accept, pick_idx};
            for (int s = 1; s < ROM_LAT; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= stage_q[ROM_LAT-1].vld;
            if (stage_q[ROM_LAT-1].vld) begin
                rsp_id   <= stage_q[ROM_LAT-1].id;
                rsp_data <= rom_data;
            end
        end
    end

    always_comb begin
        busy = rsp_valid;
        for (int s = 0; s < ROM_LAT; s++) begin
            busy = busy | stage_q[s].vld;
        end
    end

`ifdef SPRITE_ARB_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_REQ];

    // a clear coinciding with a grant counts that grant as the first of the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (frame_clr) begin
                    cnt_q[i] <= {{(STAT_W-1){1'b0}}, gnt[i]};
                end else if (gnt[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
    end
`endif

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite/tile ROM between up to NUM_REQ drawing stages, e.g. ladder, ramp, decoration and barrel overlays.
- Performs round-robin arbitration each clock, registers the winning address onto the ROM port, and returns ROM data tagged with the requester id after a fixed latency.
- Sits between the per-frame overlay stages and the single sprite ROM instance in the top-level display path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 10, ROM address width
- DATA_W, 12, ROM word width (RGB 4:4:4)
- ROM_LAT, 1, ROM read latency in cycles, from address registered to data valid (1..3)

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester access request, level
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; slice i belongs to req[i]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- rom_addr  out  ADDR_W  registered address to the ROM
- rom_data  in  DATA_W  ROM read data
- rsp_valid  out  1  returned word valid (1-cycle pulse per access)
- rsp_id  out  $clog2(NUM_REQ)  index of requester that owns rsp_data
- rsp_data  out  DATA_W  registered ROM word
- busy  out  1  at least one access is in flight in the return pipeline

Behaviour:
- Reset (rst_n=0, async): rr_ptr=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0, pipeline valids=0, busy=0. gnt is forced to 0 while rst_n=0.
- Arbitration is combinational. The winner is the first set req[i] scanning from rr_ptr upward modulo NUM_REQ. gnt is one-hot, or all zero when req==0.
- An access is accepted in cycle t when req[i]&gnt[i]=1. A requester holds req and its address until granted; it may keep req high to issue back-to-back accesses.
- Timing for an access accepted in cycle t:
  - Edge t+1: rom_addr <= req_addr[i]; pipeline stage 0 <= {valid=1, id=i}.
  - rom_data for that address is sampled ROM_LAT cycles after rom_addr updates.
  - Edge t+1+ROM_LAT: rsp_valid=1, rsp_id=i, rsp_data=rom_data.
  - Total request-to-response latency is 1+ROM_LAT cycles. Throughput is one access per cycle.
- rr_ptr update: on an accepted grant to i, rr_ptr <= (i+1) mod NUM_REQ. When there is no request, rr_ptr holds.
- With no accept, rom_addr holds its last value (avoids needless ROM toggling) and stage 0 valid=0.
- rsp_valid deasserts the cycle after the response unless another response follows.
- busy = OR of all pipeline-stage valids plus rsp_valid.
- Every requester continuously requesting: grants rotate strictly 0,1,2,3,0,... Starvation-free; worst-case wait is NUM_REQ-1 cycles.
- A new request arriving in the same cycle rr_ptr moves is handled by normal scan order with the new rr_ptr next cycle; no special case.
- Reset asserted mid-operation drops all in-flight responses immediately. No response is produced for accesses accepted before reset.
- NUM_REQ not a power of two: rr_ptr wraps explicitly at NUM_REQ-1. An id >= NUM_REQ never appears.
- Widths: rr_ptr and rsp_id are $clog2(NUM_REQ) bits. All index arithmetic wraps inside that width with an explicit compare.

Optional Feature:
- Macro SPRITE_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt (NUM_REQ*16), one saturating 16-bit counter per requester, incremented on each accepted grant.
  - Adds input frame_clr (1). A pulse on frame_clr clears all counters. If frame_clr and a grant occur in the same cycle, the counter is set to 1.
  - Reset value 0.
- Undefined: neither port exists, and no counter logic is present.

Decomposition:
- New package spritePkg holds:
  - requester index constants REQ_LADDER=0, REQ_RAMP=1, REQ_DECOR=2, REQ_BARREL=3
  - default SPRITE_ADDR_W=10, SPRITE_DATA_W=12
  - typedef sprite_rsp_t {valid, id, data}
- One sub-module, rr_pick: a pure combinational round-robin priority picker with inputs req and ptr, outputs gnt one-hot and idx. Reused later by the barrel spawn scheduler.
- The return pipeline is a local shift register, not the existing delay module, because reset polarity differs.

Test Plan:
- Single request (NUM_REQ=4, ROM_LAT=1):
  - Stimulus: req=0010 with addr 0x155 in cycle 0.
  - Response: gnt=0010 in cycle 0; rom_addr=0x155 after edge 1; rsp_valid=1, rsp_id=1, rsp_data=ROM[0x155] after edge 2; rr_ptr=2.
- Full contention:
  - Stimulus: req=1111 held for 8 cycles.
  - Response: grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical, delayed 2 cycles; rsp_valid high for 8 consecutive cycles.
- Pointer fairness:
  - Stimulus: rr_ptr=3, req=1001.
  - Response: gnt=1000 first, then gnt=0001; rr_ptr returns to 1.
- Latency parameter:
  - Stimulus: ROM_LAT=3, single access.
  - Response: rsp_valid exactly 4 cycles after accept; busy high for cycles 1..4 only.
- Reset mid-flight:
  - Stimulus: 3 back-to-back accesses, rst_n low asynchronously between edges 2 and 3.
  - Response: rsp_valid=0, busy=0, rr_ptr=0 immediately; no response after release.
- With SPRITE_ARB_STATS_EN:
  - Stimulus: req=0011 for 10 cycles, then frame_clr coincident with a grant to 0.
  - Response: counts 5/5 before the clear; counter 0 becomes 1, counter 1 becomes 0.
